host_bridge: RTL and testbench

Byte-stream bridge between the host link (UART/FIFO side) and the cracker core's `your_turn` byte handshake. It parses host command frames, loads 16-byte target hashes into the core, and issues the start command. Once cracking runs, it drains every 21-byte match report from the core and re-emits it on the host TX stream with a header byte. It sits directly upstream and downstream of the cracker top, on the same clock.

---
 rtl/hostlink_pkg.sv | 24 ++
 rtl/host_bridge_core_strobe.sv | 25 ++
 rtl/host_bridge.sv | 170 +++++++++++++++++
 tb/tb_host_bridge.sv | 368 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hostlink_pkg.sv
// Shared host-link constants and the bridge state encoding.
package hostlink_pkg;
   localparam int         HASH_BYTES   = 16;
   localparam int         REPORT_BYTES = 21;
   localparam logic [7:0] CMD_HASH     = 8'h48;
   localparam logic [7:0] CMD_GO       = 8'h47;
   localparam logic [7:0] RPT_HDR      = 8'h4D;
   localparam logic [4:0] HASH_LAST    = 5'(HASH_BYTES - 1);
   localparam logic [4:0] RPT_LAST     = 5'(REPORT_BYTES - 1);

   typedef enum logic [3:0] {
      IDLE,
      HASH_RX,
      STORE_WAIT_TURN,
      STORE_REQ,
      GO_WAIT_TURN,
      GO_REQ,
      RUN,
      TX_HDR,
      TX_BYTE,
      ACK_REQ,
      ACK_DONE
   } state_e;
endpackage

// File: rtl/host_bridge_core_strobe.sv
// Turn-based strobe: rises when requested while turn is high, drops one edge after turn falls.
// done_o marks the cycle in which the strobe is about to be released.
module core_strobe (
   input  logic clk,
   input  logic rst,
   input  logic req_i,
   input  logic turn_i,
   output logic strobe_o,
   output logic done_o
);
   logic strobe_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         strobe_q <= 1'b0;
      end else if (!strobe_q && req_i && turn_i) begin
         strobe_q <= 1'b1;
      end else if (strobe_q && !turn_i) begin
         strobe_q <= 1'b0;
      end
   end

   assign strobe_o = strobe_q;
   assign done_o   = strobe_q && !turn_i;
endmodule

// File: rtl/host_bridge.sv
// Host bridge: parses H/G command frames, loads hashes into the cracker core, then
// forwards each match report to host TX behind a header byte; TX stalls hold the core.
module host_bridge
   import hostlink_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic        rx_ready,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   input  logic        core_turn,
   input  logic        core_match,
   input  logic [7:0]  core_pwbyte,
   output logic [7:0]  core_hash_byte,
   output logic        core_store,
   output logic        core_go,
   output logic        running,
   output logic [7:0]  hash_count,
   output logic [15:0] match_count
);
   state_e      state_q;
   logic        rx_ready_q;
   logic        tx_valid_q;
   logic        tx_sel_pw_q;
   logic        running_q;
   logic [7:0]  tx_data_q;
   logic [7:0]  hash_byte_q;
   logic [7:0]  hash_count_q;
   logic [15:0] match_count_q;
   logic [4:0]  idx_q;

   logic rx_fire, tx_fire;
   logic store_req, go_req, store_done, go_done;

   assign rx_fire   = rx_valid && rx_ready_q;
   assign tx_fire   = tx_valid_q && tx_ready;
   assign store_req = (state_q == STORE_WAIT_TURN);
   // go doubles as start command and per-byte report ack; states keep it exclusive with store
   assign go_req    = (state_q == GO_WAIT_TURN) || ((state_q == TX_BYTE) && tx_fire);

   core_strobe u_store (
      .clk      (clk),
      .rst      (rst),
      .req_i    (store_req),
      .turn_i   (core_turn),
      .strobe_o (core_store),
      .done_o   (store_done)
   );

   core_strobe u_go (
      .clk      (clk),
      .rst      (rst),
      .req_i    (go_req),
      .turn_i   (core_turn),
      .strobe_o (core_go),
      .done_o   (go_done)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         rx_ready_q    <= 1'b0;
         tx_valid_q    <= 1'b0;
         tx_sel_pw_q   <= 1'b0;
         tx_data_q     <= 8'h00;
         hash_byte_q   <= 8'h00;
         running_q     <= 1'b0;
         hash_count_q  <= 8'h00;
         match_count_q <= 16'h0000;
         idx_q         <= 5'd0;
      end else begin
         unique case (state_q)
            IDLE: begin
               rx_ready_q <= 1'b1;
               if (rx_fire) begin
                  if (rx_data == CMD_HASH) begin
                     idx_q   <= 5'd0;
                     state_q <= HASH_RX;
                  end else if (rx_data == CMD_GO) begin
                     rx_ready_q <= 1'b0;
                     state_q    <= GO_WAIT_TURN;
                  end
               end
            end
            HASH_RX: begin
               if (rx_fire) begin
                  hash_byte_q <= rx_data;
                  rx_ready_q  <= 1'b0;
                  state_q     <= STORE_WAIT_TURN;
               end
            end
            STORE_WAIT_TURN: begin
               if (core_turn) state_q <= STORE_REQ;
            end
            STORE_REQ: begin
               if (store_done) begin
                  rx_ready_q <= 1'b1;
                  if (idx_q == HASH_LAST) begin
                     if (hash_count_q != 8'hFF) hash_count_q <= hash_count_q + 8'd1;
                     state_q <= IDLE;
                  end else begin
                     idx_q   <= idx_q + 5'd1;
                     state_q <= HASH_RX;
                  end
               end
            end
            GO_WAIT_TURN: begin
               if (core_turn) state_q <= GO_REQ;
            end
            GO_REQ: begin
               if (go_done) begin
                  running_q <= 1'b1;
                  state_q   <= RUN;
               end
            end
            RUN: begin
               if (core_match && core_turn) begin
                  idx_q      <= 5'd0;
                  tx_data_q  <= RPT_HDR;
                  tx_valid_q <= 1'b1;
                  state_q    <= TX_HDR;
               end
            end
            TX_HDR: begin
               if (tx_fire) begin
                  tx_sel_pw_q <= 1'b1;
                  state_q     <= TX_BYTE;
               end
            end
            TX_BYTE: begin
               if (tx_fire) begin
                  tx_valid_q  <= 1'b0;
                  tx_sel_pw_q <= 1'b0;
                  state_q     <= ACK_REQ;
               end
            end
            ACK_REQ: begin
               if (go_done) begin
                  if (idx_q == RPT_LAST) begin
                     if (match_count_q != 16'hFFFF) match_count_q <= match_count_q + 16'd1;
                     state_q <= RUN;
                  end else begin
                     idx_q   <= idx_q + 5'd1;
                     state_q <= ACK_DONE;
                  end
               end
            end
            ACK_DONE: begin
               if (core_turn && core_match) begin
                  tx_valid_q  <= 1'b1;
                  tx_sel_pw_q <= 1'b1;
                  state_q     <= TX_BYTE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign rx_ready       = rx_ready_q;
   assign tx_valid       = tx_valid_q;
   assign tx_data        = tx_sel_pw_q ? core_pwbyte : tx_data_q;
   assign core_hash_byte = hash_byte_q;
   assign running        = running_q;
   assign hash_count     = hash_count_q;
   assign match_count    = match_count_q;
endmodule

// File: tb/tb_host_bridge.sv
// Directed bench for host_bridge with a behavioural cracker-core model and TX monitor.
module tb_host_bridge;
   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        rx_ready;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic        core_turn;
   logic        core_match;
   logic [7:0]  core_pwbyte;
   logic [7:0]  core_hash_byte;
   logic        core_store;
   logic        core_go;
   logic        running;
   logic [7:0]  hash_count;
   logic [15:0] match_count;

   int errors = 0;
   int checks = 0;

   // monitor-owned counters
   int store_cnt = 0, go_start = 0, go_ack = 0, both_err = 0, hold_err = 0;
   logic store_prev = 1'b0, go_prev = 1'b0;
   logic tx_vld_prev = 1'b0, tx_xfer_prev = 1'b0;
   logic [7:0] tx_dat_prev = 8'h00;
   logic [7:0] tx_q[$];

   // core-model-owned state
   logic [7:0] store_q[$];
   int core_served = 0;
   int core_idx = 0;

   // main-owned controls
   logic [7:0] rpt [21];
   int rpt_req = 0;
   bit core_hold = 1'b0;

   host_bridge dut (
      .clk            (clk),
      .rst            (rst),
      .rx_data        (rx_data),
      .rx_valid       (rx_valid),
      .rx_ready       (rx_ready),
      .tx_data        (tx_data),
      .tx_valid       (tx_valid),
      .tx_ready       (tx_ready),
      .core_turn      (core_turn),
      .core_match     (core_match),
      .core_pwbyte    (core_pwbyte),
      .core_hash_byte (core_hash_byte),
      .core_store     (core_store),
      .core_go        (core_go),
      .running        (running),
      .hash_count     (hash_count),
      .match_count    (match_count)
   );

   always #5 clk = ~clk;

   // Core model: answers each strobe by dropping turn for two cycles; serves queued reports.
   initial begin
      core_turn = 1'b1; core_match = 1'b0; core_pwbyte = 8'h00;
      forever begin
         @(posedge clk); #2;
         if (rst) begin
            core_turn = 1'b1; core_match = 1'b0; core_idx = 0; core_served = rpt_req;
         end else begin
            if (rpt_req != core_served && !core_match) begin
               core_match = 1'b1; core_idx = 0; core_pwbyte = rpt[0];
            end
            if (!core_hold && (core_store || core_go)) begin
               if (core_store) store_q.push_back(core_hash_byte);
               core_turn = 1'b0;
               while (core_store || core_go) begin @(posedge clk); #2; end
               @(posedge clk); #2;
               if (core_match) begin
                  core_idx++;
                  if (core_idx == 21) begin
                     core_match = 1'b0; core_served++;
                  end else begin
                     core_pwbyte = rpt[core_idx];
                  end
               end
               core_turn = 1'b1;
            end
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (core_store && !store_prev) store_cnt++;
         if (core_go && !go_prev) begin
            if (core_match) go_ack++; else go_start++;
         end
         if (core_store && core_go) both_err++;
         if (!rst && tx_vld_prev && !tx_xfer_prev && (!tx_valid || tx_data !== tx_dat_prev)) hold_err++;
         if (tx_valid && tx_ready) tx_q.push_back(tx_data);
         store_prev   = core_store;
         go_prev      = core_go;
         tx_vld_prev  = tx_valid;
         tx_xfer_prev = tx_valid && tx_ready;
         tx_dat_prev  = tx_data;
      end
   end

   task automatic send_byte(input logic [7:0] b, input int budget, output bit ok);
      ok = 1'b0; rx_data = b; rx_valid = 1'b1;
      for (int i = 0; i < budget && !ok; i++) begin
         @(negedge clk);
         if (rx_ready) ok = 1'b1;
         @(posedge clk); #1;
      end
      rx_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      @(negedge clk);
      checks++;
      if ({rx_ready, tx_valid, core_store, core_go, running} !== 5'b0) begin
         errors++; $display("FAIL reset_flags: got %b want 00000", {rx_ready, tx_valid, core_store, core_go, running});
      end
      checks++;
      if (tx_data !== 8'h00 || core_hash_byte !== 8'h00) begin
         errors++; $display("FAIL reset_data: got tx=%h hb=%h want 00 00", tx_data, core_hash_byte);
      end
      checks++;
      if (hash_count !== 8'd0 || match_count !== 16'd0) begin
         errors++; $display("FAIL reset_counts: got %0d %0d want 0 0", hash_count, match_count);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (rx_ready !== 1'b0) begin
         errors++; $display("FAIL reset_rdy_early: got %b want 0", rx_ready);
      end
      @(negedge clk);
      checks++;
      if (rx_ready !== 1'b1) begin
         errors++; $display("FAIL reset_rdy_first: got %b want 1", rx_ready);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_hash_load();
      bit ok;
      int to = 0, bad = 0;
      int sbase = store_q.size();
      int cbase = store_cnt;
      send_byte(8'h48, 20, ok); if (!ok) to++;
      for (int i = 0; i < 16; i++) begin
         send_byte(8'(i), 20, ok); if (!ok) to++;
      end
      for (int n = 0; n < 100 && hash_count !== 8'd1; n++) @(negedge clk);
      checks++;
      if (hash_count !== 8'd1 || to != 0) begin
         errors++; $display("FAIL hash_load_count: got %0d (rx timeouts %0d) want 1", hash_count, to);
      end
      checks++;
      if (store_cnt - cbase != 16 || store_q.size() - sbase != 16) begin
         errors++; $display("FAIL hash_load_pulses: got %0d stores want 16", store_cnt - cbase);
      end
      for (int i = 0; i < 16; i++)
         if (sbase + i >= store_q.size() || store_q[sbase + i] !== 8'(i)) bad++;
      checks++;
      if (bad != 0) begin
         errors++; $display("FAIL hash_load_bytes: got %0d wrong bytes want 0", bad);
      end
      @(negedge clk);
      checks++;
      if (rx_ready !== 1'b1 || go_start != 0) begin
         errors++; $display("FAIL hash_load_idle: got rdy=%b go=%0d want 1 0", rx_ready, go_start);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_cmd_in_data();
      bit ok;
      int to = 0, bad = 0;
      int sbase = store_q.size();
      logic [7:0] exp [16];
      exp[0] = 8'h47; exp[1] = 8'h48;
      for (int i = 2; i < 16; i++) exp[i] = 8'hA0 + 8'(i);
      send_byte(8'h13, 20, ok); if (!ok) to++;
      send_byte(8'h48, 20, ok); if (!ok) to++;
      for (int i = 0; i < 16; i++) begin
         send_byte(exp[i], 20, ok); if (!ok) to++;
      end
      for (int n = 0; n < 100 && hash_count !== 8'd2; n++) @(negedge clk);
      checks++;
      if (hash_count !== 8'd2 || to != 0) begin
         errors++; $display("FAIL cmd_data_count: got %0d (rx timeouts %0d) want 2", hash_count, to);
      end
      for (int i = 0; i < 16; i++)
         if (sbase + i >= store_q.size() || store_q[sbase + i] !== exp[i]) bad++;
      checks++;
      if (bad != 0 || store_q.size() - sbase != 16) begin
         errors++; $display("FAIL cmd_data_bytes: got %0d wrong, %0d stored want 0 wrong, 16 stored", bad, store_q.size() - sbase);
      end
      checks++;
      if (go_start != 0) begin
         errors++; $display("FAIL cmd_data_nogo: got %0d go pulses want 0", go_start);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_go();
      bit ok;
      int cbase = store_cnt;
      send_byte(8'h47, 20, ok);
      for (int n = 0; n < 100 && running !== 1'b1; n++) @(negedge clk);
      checks++;
      if (running !== 1'b1 || !ok) begin
         errors++; $display("FAIL go_running: got %b want 1", running);
      end
      repeat (5) @(negedge clk);
      checks++;
      if (go_start != 1) begin
         errors++; $display("FAIL go_pulses: got %0d want 1", go_start);
      end
      checks++;
      if (rx_ready !== 1'b0) begin
         errors++; $display("FAIL go_rx_stall: got %b want 0", rx_ready);
      end
      @(posedge clk); #1;
      send_byte(8'h48, 20, ok);
      checks++;
      if (ok || store_cnt != cbase || hash_count !== 8'd2) begin
         errors++; $display("FAIL go_reject_byte: got accepted=%b stores=%0d want 0 0", ok, store_cnt - cbase);
      end
   endtask

   task automatic check_stream(input string name, input int base);
      int bad = 0;
      logic [7:0] e;
      for (int i = 0; i < 22; i++) begin
         e = (i == 0) ? 8'h4D : rpt[i - 1];
         if (base + i >= tx_q.size() || tx_q[base + i] !== e) bad++;
      end
      checks++;
      if (bad != 0 || tx_q.size() - base != 22) begin
         errors++; $display("FAIL %s_stream: got %0d bytes, %0d wrong want 22 bytes, 0 wrong", name, tx_q.size() - base, bad);
      end
   endtask

   task automatic test_report();
      int base = tx_q.size();
      int ack0 = go_ack;
      rpt[0] = 8'h61; rpt[1] = 8'h62; rpt[2] = 8'h63;
      for (int i = 3; i < 20; i++) rpt[i] = 8'h20;
      rpt[20] = 8'h03;
      tx_ready = 1'b1;
      rpt_req++;
      for (int n = 0; n < 600 && match_count !== 16'd1; n++) @(negedge clk);
      checks++;
      if (match_count !== 16'd1) begin
         errors++; $display("FAIL report_count: got %0d want 1", match_count);
      end
      check_stream("report", base);
      checks++;
      if (go_ack - ack0 != 21 || go_start != 1 || both_err != 0) begin
         errors++; $display("FAIL report_acks: got %0d acks, %0d starts, %0d overlaps want 21 1 0", go_ack - ack0, go_start, both_err);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_backpressure();
      int base = tx_q.size();
      int ack0 = go_ack;
      int ack_mid = 0, bad_go = 0, bad_vld = 0, bad_dat = 0;
      bit stalled = 1'b0;
      rpt_req++;
      for (int n = 0; n < 2000 && match_count !== 16'd2; n++) begin
         @(posedge clk); #1;
         if (!stalled && tx_q.size() - base == 5) begin
            stalled = 1'b1;
            tx_ready = 1'b0;
            repeat (10) @(negedge clk);
            ack_mid = go_ack;
            repeat (40) begin
               @(negedge clk);
               if (core_go) bad_go++;
               if (tx_valid !== 1'b1) bad_vld++;
               if (tx_data !== 8'h20) bad_dat++;
            end
            checks++;
            if (bad_go != 0 || go_ack != ack_mid) begin
               errors++; $display("FAIL bp_go_low: got %0d go cycles want 0", bad_go);
            end
            checks++;
            if (bad_vld != 0 || bad_dat != 0) begin
               errors++; $display("FAIL bp_hold: got %0d invalid, %0d wrong-data cycles want 0 0", bad_vld, bad_dat);
            end
            @(posedge clk); #1;
            tx_ready = 1'b1;
         end
      end
      checks++;
      if (match_count !== 16'd2 || !stalled) begin
         errors++; $display("FAIL bp_count: got %0d (stalled=%b) want 2", match_count, stalled);
      end
      check_stream("bp", base);
      checks++;
      if (go_ack - ack0 != 21 || hold_err != 0) begin
         errors++; $display("FAIL bp_acks: got %0d acks, %0d hold errors want 21 0", go_ack - ack0, hold_err);
      end
   endtask

   task automatic test_reset_mid();
      bit ok;
      int to = 0;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      core_hold = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      send_byte(8'h48, 20, ok); if (!ok) to++;
      send_byte(8'h05, 20, ok); if (!ok) to++;
      for (int n = 0; n < 20 && core_store !== 1'b1; n++) begin @(posedge clk); #1; end
      checks++;
      if (core_store !== 1'b1 || to != 0) begin
         errors++; $display("FAIL mid_store_up: got %b want 1", core_store);
      end
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (core_store !== 1'b0 || core_go !== 1'b0) begin
         errors++; $display("FAIL mid_strobe_drop: got store=%b go=%b want 0 0", core_store, core_go);
      end
      checks++;
      if (hash_count !== 8'd0 || match_count !== 16'd0 || running !== 1'b0 || rx_ready !== 1'b0) begin
         errors++; $display("FAIL mid_counters: got h=%0d m=%0d run=%b rdy=%b want 0 0 0 0", hash_count, match_count, running, rx_ready);
      end
      core_hold = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (rx_ready !== 1'b1 || core_hash_byte !== 8'h00) begin
         errors++; $display("FAIL mid_idle: got rdy=%b hb=%h want 1 00", rx_ready, core_hash_byte);
      end
   endtask

   initial begin
      rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; tx_ready = 1'b0;
      test_reset();
      test_hash_load();
      test_cmd_in_data();
      test_go();
      test_report();
      test_backpressure();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
